hilo_muldiv_unit: RTL and testbench

- Multiply/divide execution unit, downstream of the register-file read stage. It owns the architectural HI/LO registers.
- Consumes rs/rt operand values and a decoded op from the controller. Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Exposes HI/LO continuously for MFHI/MFLO result muxing.
- Asserts busy while an operation is in flight; the CPU stalls PC and regfile writes on busy.

---
 rtl/hilo_muldiv_unit.sv | 168 ++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// Multiply/divide unit owning the architectural HI/LO registers.
// Multiplies complete after MULT_STAGES cycles; divides use a 32-step restoring shift-subtract.
module hilo_muldiv_unit #(
  parameter int MULT_STAGES = 2,
  parameter int DIV_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [5:0] MUL_LAST = 6'(MULT_STAGES - 1);
  localparam logic [5:0] DIV_LAST = 6'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sgn_q, sgn_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;

  logic [63:0] ext_a, ext_b, prod;
  logic [32:0] rem_sh;
  logic        fits;
  logic [31:0] rem_nx, quo_nx;
  logic        q_neg, r_neg;
  logic [31:0] quo_fin, rem_fin;
  logic        acc_sgn;

  // Multiply: sign-extend to 64 bits so a single 64-bit product covers both forms.
  always_comb begin
    ext_a = {{32{sgn_q & a_q[31]}}, a_q};
    ext_b = {{32{sgn_q & b_q[31]}}, b_q};
    prod  = ext_a * ext_b;
  end

  // One restoring divide step; quotient bits shift in from the bottom of quo_q
  // while dividend bits shift out of its top into the partial remainder.
  always_comb begin
    rem_sh  = {rem_q, quo_q[31]};
    fits    = (rem_sh >= {1'b0, dvs_q});
    rem_nx  = fits ? 32'(rem_sh - {1'b0, dvs_q}) : rem_sh[31:0];
    quo_nx  = {quo_q[30:0], fits};
    q_neg   = sgn_q & (a_q[31] ^ b_q[31]);
    r_neg   = sgn_q & a_q[31];
    quo_fin = q_neg ? -quo_nx : quo_nx;
    rem_fin = r_neg ? -rem_nx : rem_nx;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    acc_sgn = ~op[0];
    if (clk_enable) begin
      case (state_q)
        S_IDLE: if (start) begin
          case (op)
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            OP_MULT, OP_MULTU: begin
              a_d     = rs_val;
              b_d     = rt_val;
              sgn_d   = acc_sgn;
              cnt_d   = MUL_LAST;
              state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              a_d     = rs_val;
              b_d     = rt_val;
              sgn_d   = acc_sgn;
              rem_d   = 32'd0;
              quo_d   = (acc_sgn & rs_val[31]) ? -rs_val : rs_val;
              dvs_d   = (acc_sgn & rt_val[31]) ? -rt_val : rt_val;
              cnt_d   = DIV_LAST;
              state_d = S_DIV;
            end
            default: ;
          endcase
        end
        S_MUL: begin
          if (cnt_q == 6'd0) begin
            {hi_d, lo_d} = prod;
            state_d      = S_IDLE;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        S_DIV: begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          if (cnt_q == 6'd0) begin
            // Divide by zero still takes the full latency, then reports the dividend.
            if (b_q == 32'd0) begin
              hi_d = a_q;
              lo_d = 32'hFFFF_FFFF;
            end else begin
              hi_d = rem_fin;
              lo_d = quo_fin;
            end
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sgn_q   <= 1'b0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed vector table, random ops against an
// arithmetic reference model, plus freeze and mid-operation reset sequences.
module tb_hilo_muldiv_unit;
  localparam int MS = 2;

  logic        clk = 1'b0;
  logic        reset, clk_enable, start;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_hi, m_lo;

  hilo_muldiv_unit #(.MULT_STAGES(MS), .DIV_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs, rt, hi, lo;
    int          cyc;
  } vec_t;
  vec_t vt[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_cyc(input logic [2:0] o);
    if (o == 3'd0 || o == 3'd1) return MS;
    if (o == 3'd2 || o == 3'd3) return 32;
    return 0;
  endfunction

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint p, q, r;
    longint unsigned up;
    case (o)
      3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = p; end
      3'd1: begin up = longint'({32'd0, a}) * longint'({32'd0, b}); {m_hi, m_lo} = up; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          m_hi = a; m_lo = 32'hFFFF_FFFF;
        end else begin
          if (o == 3'd2) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
          end else begin
            q = longint'({32'd0, a}) / longint'({32'd0, b});
            r = longint'({32'd0, a}) % longint'({32'd0, b});
          end
          m_lo = q[31:0]; m_hi = r[31:0];
        end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  // Called just after a falling edge; returns just after the falling edge where busy is low.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc;
    logic [2:0] o;
    logic [31:0] a, b;

    vt[0] = '{3'd4, 32'h12345678, 32'h0, 32'h12345678, 32'h0,        0};
    vt[1] = '{3'd5, 32'h9ABCDEF0, 32'h0, 32'h12345678, 32'h9ABCDEF0, 0};
    vt[2] = '{3'd0, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, MS};
    vt[3] = '{3'd1, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA, MS};
    vt[4] = '{3'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 32};
    vt[5] = '{3'd3, 32'd100,      32'd7, 32'd2,        32'd14,       32};
    vt[6] = '{3'd3, 32'h55,       32'h0, 32'h55,       32'hFFFFFFFF, 32};
    vt[7] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 32};
    vt[8] = '{3'd6, 32'h1,        32'h1, 32'h0,        32'h80000000, 0};
    vt[9] = '{3'd2, 32'h80000005, 32'h0, 32'h80000005, 32'hFFFFFFFF, 32};

    reset = 1'b1; clk_enable = 1'b1; start = 1'b0; op = 3'd0; rs_val = 32'd0; rt_val = 32'd0;
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    @(negedge clk); reset = 1'b0;

    foreach (vt[i]) begin
      run_op(vt[i].op, vt[i].rs, vt[i].rt, cyc);
      check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vt[i].cyc));
      check($sformatf("vec%0d_hi", i), hi, vt[i].hi);
      check($sformatf("vec%0d_lo", i), lo, vt[i].lo);
    end
    m_hi = hi; m_lo = lo;
    if (n_bad != 0) begin m_hi = vt[9].hi; m_lo = vt[9].lo; end

    // Random back-to-back ops against the model.
    for (int k = 0; k < 40; k++) begin
      o = 3'($urandom_range(0, 7));
      a = rnd_val();
      b = rnd_val();
      model(o, a, b);
      run_op(o, a, b, cyc);
      check($sformatf("rnd%0d_op%0d_cycles", k, o), 32'(cyc), 32'(exp_cyc(o)));
      check($sformatf("rnd%0d_op%0d_hi", k, o), hi, m_hi);
      check($sformatf("rnd%0d_op%0d_lo", k, o), lo, m_lo);
      m_hi = hi; m_lo = lo;
    end

    // DIV with a 5-cycle freeze and a stray MTHI while busy.
    model(3'd2, 32'hFFFFFF9C, 32'd7);
    op = 3'd2; rs_val = 32'hFFFFFF9C; rt_val = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
      clk_enable = !(cyc >= 3 && cyc < 8);
      if (cyc == 10) begin
        start = 1'b1; op = 3'd4; rs_val = 32'hDEADBEEF;
      end else begin
        start = 1'b0;
      end
    end
    clk_enable = 1'b1; start = 1'b0;
    check("freeze_cycles", 32'(cyc), 32'd37);
    check("freeze_hi", hi, m_hi);
    check("freeze_lo", lo, m_lo);

    // Asynchronous reset in the middle of a DIVU.
    op = 3'd3; rs_val = 32'hFFFF0000; rt_val = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (15) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_hi", hi, 32'd0);
    check("async_rst_lo", lo, 32'd0);
    @(negedge clk); reset = 1'b0;
    run_op(3'd1, 32'd3, 32'd4, cyc);
    check("post_rst_cycles", 32'(cyc), 32'(MS));
    check("post_rst_hi", hi, 32'd0);
    check("post_rst_lo", lo, 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
